alu_md_seq: RTL

Iterative unsigned multiply/divide sequencer (MULTU/DIVU) that has no adder of its own. It borrows the shared 32-bit ALU one operation per iteration through a request/grant port, and the pipeline owns the grant. It runs shift-add multiply and restoring divide over 32 iterations and returns HI/LO. It sits beside the ALU in the execute stage; the hazard unit stalls on busy.

---
 rtl/alu_md_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_md_seq.sv
// alu_md_seq -- iterative unsigned multiply / divide sequencer (MULTU / DIVU).
//
// The sequencer owns no adder. Every add (multiply) or subtract (divide)
// step is borrowed from the shared 32-bit ALU through a request/grant
// handshake whose grant is decided by the pipeline. Each operation runs
// 32 iterations (shift-add multiply, restoring divide). The result appears
// on hi/lo in the same cycle as the one-cycle done pulse.
//
// Ports:
//   clk      in   clock
//   rstn     in   synchronous reset, active-low
//   start    in   one-cycle request, sampled only while idle
//   op       in   0 = MULTU, 1 = DIVU
//   opa      in   [31:0] multiplicand / dividend, captured at start
//   opb      in   [31:0] multiplier / divisor, captured at start
//   alu_req  out  sequencer wants the shared ALU this cycle
//   alu_gnt  in   ALU granted this cycle (combinational from the arbiter)
//   alu_op   out  [4:0] ALU_ADDU / ALU_SUBU, ALU_NOP when not requesting
//   alu_a    out  [31:0] ALU operand A, 0 when not requesting
//   alu_b    out  [31:0] ALU operand B, 0 when not requesting
//   alu_c    in   [31:0] ALU result, same cycle
//   busy     out  high from the cycle after an accepted start through DONE
//   done     out  one-cycle completion pulse
//   hi       out  [31:0] product high word / remainder
//   lo       out  [31:0] product low word / quotient

`ifndef ALU_NOP
`define ALU_NOP  5'd0
`endif
`ifndef ALU_ADDU
`define ALU_ADDU 5'd1
`endif
`ifndef ALU_SUBU
`define ALU_SUBU 5'd3
`endif

module alu_md_seq #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_c,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        op_r;
    logic [31:0] w_hi, w_lo, d;
    logic [5:0]  cnt;

    logic        granted, iter_done, last_iter, div0;
    logic        t_bit, mul_carry;
    logic [31:0] r_sh, q_sh, mul_sum;
    logic [31:0] hi_nxt, lo_nxt;

    assign div0 = op & (opb == 32'd0);

    // One iteration of the working registers, given this cycle's grant.
    always_comb begin
        granted   = alu_req & alu_gnt;
        t_bit     = w_hi[31];
        r_sh      = {w_hi[30:0], w_lo[31]};
        q_sh      = {w_lo[30:0], 1'b0};
        mul_sum   = granted ? alu_c : w_hi;
        // Carry out of W_HI + D recovered from the wrapped sum.
        mul_carry = granted & (alu_c < w_hi);
        iter_done = 1'b0;
        hi_nxt    = w_hi;
        lo_nxt    = w_lo;
        if (state == S_ITER) begin
            if (op_r) begin
                iter_done = granted;
                // Bit shifted out of W_HI means R >= D regardless of compare.
                if (t_bit | (r_sh >= d)) begin
                    hi_nxt = alu_c;
                    lo_nxt = q_sh | 32'd1;
                end else begin
                    hi_nxt = r_sh;
                    lo_nxt = q_sh;
                end
            end else begin
                // No add needed when the multiplier bit is clear.
                iter_done = ~w_lo[0] | granted;
                {hi_nxt, lo_nxt} = {mul_carry, mul_sum, w_lo[31:1]};
            end
        end
    end

    assign last_iter = iter_done & (cnt == 6'd31);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = div0 ? S_DONE : S_ITER;
            S_ITER:  if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        alu_req = (state == S_ITER) & (op_r | w_lo[0]);
        alu_op  = `ALU_NOP;
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        if (alu_req) begin
            alu_op = op_r ? `ALU_SUBU : `ALU_ADDU;
            alu_a  = op_r ? r_sh : w_hi;
            alu_b  = d;
        end
    end

    // Working registers and results. hi/lo are loaded on entry to DONE so
    // they are valid while done is high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_r <= 1'b0;
            w_hi <= 32'd0;
            w_lo <= 32'd0;
            d    <= 32'd0;
            cnt  <= 6'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r <= op;
                        if (div0) begin
                            w_hi <= opa;
                            w_lo <= DIV0_LO;
                            hi   <= opa;
                            lo   <= DIV0_LO;
                        end else begin
                            w_hi <= 32'd0;
                            w_lo <= opa;
                            d    <= opb;
                            cnt  <= 6'd0;
                        end
                    end
                end
                S_ITER: begin
                    if (iter_done) begin
                        w_hi <= hi_nxt;
                        w_lo <= lo_nxt;
                        cnt  <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            hi <= hi_nxt;
                            lo <= lo_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
